// File: rtl/drum_motor_drive.sv
// rtl/drum_motor_drive.sv - washing-machine drum motor drive: ramped spin, tumble, imbalance retry, stall fault
module drum_motor_drive #(
  parameter logic [15:0] TICK_DIV      = 16'd1000,
  parameter logic [10:0] RAMP_STEP     = 11'd50,
  parameter logic [10:0] TUMBLE_SPEED  = 11'd50,
  parameter logic [7:0]  TUMBLE_TICKS  = 8'd20,
  parameter logic [7:0]  PAUSE_TICKS   = 8'd5,
  parameter logic [10:0] VIB_MIN_SPEED = 11'd400,
  parameter logic [1:0]  MAX_RETRY     = 2'd3,
  parameter logic [7:0]  STALL_TICKS   = 8'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        drum_motor,
  input  logic [10:0] target_speed,
  input  logic [10:0] motor_speed_sensor,
  input  logic        vibration_sensor,
  input  logic        clear_fault,
  output logic        motor_en,
  output logic        motor_dir,
  output logic        motor_pwm,
  output logic [10:0] speed_cmd,
  output logic        at_speed,
  output logic        imbalance_fault,
  output logic        stall_fault,
  output logic        drum_stopped
);

  typedef enum logic [2:0] {
    IDLE, RAMP_UP, AT_SPEED, RAMP_DOWN, TUMBLE_RUN, TUMBLE_PAUSE, FAULT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [10:0] target_lat, target_nxt, speed_nxt;
  logic [1:0]  retry_cnt, retry_cnt_nxt;
  logic        retry_flag, retry_flag_nxt;
  logic [7:0]  stall_cnt, stall_nxt;
  logic [7:0]  phase_cnt, phase_nxt;
  logic        dir_nxt, imb_nxt, stf_nxt;

  logic        tick;
  logic [11:0] ramp_sum;
  logic [10:0] ramp_up_val, ramp_dn_val, clamped;
  logic        stalled, stall_hit;

  assign tick        = (pre_cnt == TICK_DIV - 16'd1);
  assign ramp_sum    = {1'b0, speed_cmd} + {1'b0, RAMP_STEP};
  assign ramp_up_val = (ramp_sum >= {1'b0, target_lat}) ? target_lat : ramp_sum[10:0];
  assign ramp_dn_val = (speed_cmd > RAMP_STEP) ? (speed_cmd - RAMP_STEP) : 11'd0;
  assign clamped     = (target_speed > 11'd1400) ? 11'd1400 : target_speed;
  // A drum turning at less than a quarter of the reference is treated as stalled.
  assign stalled     = (speed_cmd >= 11'd200) && (motor_speed_sensor < (speed_cmd >> 2));
  assign stall_hit   = stalled && ((stall_cnt + 8'd1) == STALL_TICKS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      speed_cmd       <= 11'd0;
      target_lat      <= 11'd0;
      retry_cnt       <= 2'd0;
      retry_flag      <= 1'b0;
      stall_cnt       <= 8'd0;
      phase_cnt       <= 8'd0;
      motor_dir       <= 1'b0;
      imbalance_fault <= 1'b0;
      stall_fault     <= 1'b0;
    end else begin
      state           <= state_nxt;
      speed_cmd       <= speed_nxt;
      target_lat      <= target_nxt;
      retry_cnt       <= retry_cnt_nxt;
      retry_flag      <= retry_flag_nxt;
      stall_cnt       <= stall_nxt;
      phase_cnt       <= phase_nxt;
      motor_dir       <= dir_nxt;
      imbalance_fault <= imb_nxt;
      stall_fault     <= stf_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt      <= 16'd0;
      pwm_cnt      <= 8'd0;
      drum_stopped <= 1'b0;
    end else begin
      pre_cnt      <= tick ? 16'd0 : pre_cnt + 16'd1;
      pwm_cnt      <= pwm_cnt + 8'd1;
      drum_stopped <= (speed_cmd == 11'd0) && (motor_speed_sensor == 11'd0);
    end
  end

  always_comb begin
    state_nxt      = state;
    speed_nxt      = speed_cmd;
    target_nxt     = target_lat;
    retry_cnt_nxt  = retry_cnt;
    retry_flag_nxt = retry_flag;
    stall_nxt      = 8'd0;
    phase_nxt      = phase_cnt;
    dir_nxt        = motor_dir;
    imb_nxt        = imbalance_fault;
    stf_nxt        = stall_fault;

    case (state)
      IDLE: begin
        speed_nxt      = 11'd0;
        retry_cnt_nxt  = 2'd0;
        retry_flag_nxt = 1'b0;
        phase_nxt      = 8'd0;
        if (drum_motor) begin
          target_nxt = clamped;
          if (clamped == 11'd0) begin
            state_nxt = TUMBLE_RUN;
            speed_nxt = TUMBLE_SPEED;
          end else begin
            state_nxt = RAMP_UP;
            dir_nxt   = 1'b0;
          end
        end
      end

      RAMP_UP, AT_SPEED: begin
        stall_nxt = stall_cnt;
        if (tick) stall_nxt = stalled ? stall_cnt + 8'd1 : 8'd0;
        // Priority: stall, then run-request drop, then imbalance.
        if (tick && stall_hit) begin
          state_nxt = FAULT;
          stf_nxt   = 1'b1;
          speed_nxt = 11'd0;
          stall_nxt = 8'd0;
        end else if (!drum_motor) begin
          state_nxt = RAMP_DOWN;
        end else if (tick && vibration_sensor && (speed_cmd > VIB_MIN_SPEED)) begin
          state_nxt      = RAMP_DOWN;
          retry_flag_nxt = 1'b1;
        end else if (tick && (state == RAMP_UP)) begin
          speed_nxt = ramp_up_val;
          if (ramp_up_val == target_lat) state_nxt = AT_SPEED;
        end
      end

      RAMP_DOWN: begin
        if (speed_cmd == 11'd0) begin
          if (retry_flag && (retry_cnt == MAX_RETRY)) begin
            state_nxt = FAULT;
            imb_nxt   = 1'b1;
          end else if (retry_flag && drum_motor) begin
            state_nxt     = RAMP_UP;
            retry_cnt_nxt = retry_cnt + 2'd1;
            dir_nxt       = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tick) begin
          speed_nxt = ramp_dn_val;
        end
      end

      TUMBLE_RUN: begin
        if (!drum_motor) begin
          state_nxt = IDLE;
          speed_nxt = 11'd0;
          phase_nxt = 8'd0;
        end else if (tick) begin
          if (phase_cnt == TUMBLE_TICKS - 8'd1) begin
            state_nxt = TUMBLE_PAUSE;
            speed_nxt = 11'd0;
            phase_nxt = 8'd0;
          end else begin
            phase_nxt = phase_cnt + 8'd1;
          end
        end
      end

      TUMBLE_PAUSE: begin
        speed_nxt = 11'd0;
        if (!drum_motor) begin
          state_nxt = IDLE;
          phase_nxt = 8'd0;
        end else if (tick) begin
          if (phase_cnt == PAUSE_TICKS - 8'd1) begin
            state_nxt = TUMBLE_RUN;
            speed_nxt = TUMBLE_SPEED;
            phase_nxt = 8'd0;
            dir_nxt   = ~motor_dir;
          end else begin
            phase_nxt = phase_cnt + 8'd1;
          end
        end
      end

      FAULT: begin
        speed_nxt = 11'd0;
        if (clear_fault && !drum_motor) begin
          state_nxt = IDLE;
          imb_nxt   = 1'b0;
          stf_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        speed_nxt = 11'd0;
      end
    endcase
  end

  always_comb begin
    motor_en = 1'b0;
    case (state)
      RAMP_UP, AT_SPEED, TUMBLE_RUN: motor_en = 1'b1;
      RAMP_DOWN:                     motor_en = (speed_cmd != 11'd0);
      default:                       motor_en = 1'b0;
    endcase
  end

  assign at_speed  = (state == AT_SPEED);
  assign motor_pwm = motor_en & (pwm_cnt < speed_cmd[10:3]);

endmodule

// File: tb/tb_drum_motor_drive.sv
// tb/tb_drum_motor_drive.sv - directed self-checking bench for drum_motor_drive with a 4-clock tick
module tb_drum_motor_drive;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        drum_motor = 1'b0;
  logic [10:0] target_speed = 11'd0;
  logic [10:0] motor_speed_sensor;
  logic        vibration_sensor;
  logic        clear_fault = 1'b0;
  logic        motor_en, motor_dir, motor_pwm;
  logic [10:0] speed_cmd;
  logic        at_speed, imbalance_fault, stall_fault, drum_stopped;

  int sens_mode = 0;
  int vib_mode  = 0;
  int cyc = 0;
  int passes = 0;
  int fails = 0;
  int total = 0;

  // Plant model: the drum follows the reference unless told to stall above 200 rpm.
  assign motor_speed_sensor = (sens_mode == 1 && speed_cmd >= 11'd200) ? 11'd0 : speed_cmd;
  assign vibration_sensor   = (vib_mode == 1) ? (speed_cmd >= 11'd600) :
                              (vib_mode == 2) ? (speed_cmd == 11'd650) : 1'b0;

  drum_motor_drive #(.TICK_DIV(16'd4)) dut (
    .clk(clk), .reset(reset), .drum_motor(drum_motor), .target_speed(target_speed),
    .motor_speed_sensor(motor_speed_sensor), .vibration_sensor(vibration_sensor),
    .clear_fault(clear_fault), .motor_en(motor_en), .motor_dir(motor_dir),
    .motor_pwm(motor_pwm), .speed_cmd(speed_cmd), .at_speed(at_speed),
    .imbalance_fault(imbalance_fault), .stall_fault(stall_fault), .drum_stopped(drum_stopped)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int prev, nchg, bad, badint, lastcyc, runs, peak, cnt, n;

    // Reset state
    #2;
    chk("rst_speed", speed_cmd, 0);
    chk("rst_en", motor_en, 0);
    chk("rst_dir", motor_dir, 0);
    chk("rst_pwm", motor_pwm, 0);
    chk("rst_at_speed", at_speed, 0);
    chk("rst_imb", imbalance_fault, 0);
    chk("rst_stall", stall_fault, 0);
    chk("rst_stopped", drum_stopped, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("stopped_after_release", drum_stopped, 1);

    // Ramp up to 1000; mid-ramp target change must be ignored
    target_speed = 11'd1000;
    drum_motor = 1'b1;
    prev = 0; nchg = 0; bad = 0; badint = 0; lastcyc = 0; n = 0;
    while (speed_cmd != 11'd1000 && n < 300) begin
      step(); n++;
      if (int'(speed_cmd) != prev) begin
        if (int'(speed_cmd) != prev + 50) bad++;
        if (nchg > 0 && cyc - lastcyc != 4) badint++;
        lastcyc = cyc; nchg++; prev = int'(speed_cmd);
        if (speed_cmd == 11'd500) target_speed = 11'd300;
      end
      if (at_speed && speed_cmd != 11'd1000) bad++;
    end
    chk("up_final_speed", speed_cmd, 1000);
    chk("up_tick_count", nchg, 20);
    chk("up_step_errors", bad, 0);
    chk("up_tick_interval_errors", badint, 0);
    chk("up_at_speed", at_speed, 1);
    chk("up_motor_en", motor_en, 1);
    chk("up_dir", motor_dir, 0);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (motor_pwm) cnt++;
    end
    chk("pwm_duty_1000", cnt, 125);
    chk("hold_speed", speed_cmd, 1000);

    // Ramp down to IDLE
    drum_motor = 1'b0;
    step();
    chk("down_at_speed_drop", at_speed, 0);
    prev = 1000; nchg = 0; bad = 0; n = 0;
    while (speed_cmd != 11'd0 && n < 300) begin
      step(); n++;
      if (int'(speed_cmd) != prev) begin
        if (int'(speed_cmd) != prev - 50) bad++;
        nchg++; prev = int'(speed_cmd);
        if (motor_en != (speed_cmd != 11'd0)) bad++;
      end
    end
    chk("down_final_speed", speed_cmd, 0);
    chk("down_tick_count", nchg, 20);
    chk("down_errors", bad, 0);
    chk("down_en_at_zero", motor_en, 0);
    step(); step();
    chk("down_stopped", drum_stopped, 1);
    chk("down_idle_en", motor_en, 0);

    // Imbalance at 600 on every run: 3 retries then FAULT
    vib_mode = 1;
    target_speed = 11'd1000;
    drum_motor = 1'b1;
    prev = 0; runs = 0; peak = 0; n = 0;
    while (!imbalance_fault && n < 3000) begin
      step(); n++;
      if (prev == 0 && speed_cmd != 11'd0) runs++;
      if (int'(speed_cmd) > peak) peak = int'(speed_cmd);
      prev = int'(speed_cmd);
    end
    chk("imb_fault", imbalance_fault, 1);
    chk("imb_runs", runs, 4);
    chk("imb_peak", peak, 600);
    chk("imb_speed", speed_cmd, 0);
    chk("imb_en", motor_en, 0);
    chk("imb_no_stall", stall_fault, 0);
    clear_fault = 1'b1;
    step(); step(); step();
    chk("imb_sticky_with_run", imbalance_fault, 1);
    drum_motor = 1'b0;
    step();
    chk("imb_cleared", imbalance_fault, 0);
    clear_fault = 1'b0;
    vib_mode = 0;
    step();

    // Tumble: 50 rpm for 20 ticks, pause 5 ticks, direction toggles
    target_speed = 11'd0;
    drum_motor = 1'b1;
    n = 0;
    while (speed_cmd != 11'd50 && n < 20) begin step(); n++; end
    chk("tumble_en", motor_en, 1);
    chk("tumble_dir0", motor_dir, 0);
    cnt = 0;
    while (speed_cmd == 11'd50 && cnt < 200) begin step(); cnt++; end
    chk("tumble_run1_len_ok", int'(cnt >= 77 && cnt <= 80), 1);
    chk("pause_en", motor_en, 0);
    cnt = 0;
    while (speed_cmd == 11'd0 && cnt < 200) begin step(); cnt++; end
    chk("pause1_len", cnt, 20);
    chk("tumble_dir1", motor_dir, 1);
    cnt = 0;
    while (speed_cmd == 11'd50 && cnt < 200) begin step(); cnt++; end
    chk("tumble_run2_len", cnt, 80);
    cnt = 0;
    while (speed_cmd == 11'd0 && cnt < 200) begin step(); cnt++; end
    chk("pause2_len", cnt, 20);
    chk("tumble_dir2", motor_dir, 0);
    drum_motor = 1'b0;
    step();
    chk("tumble_stop_speed", speed_cmd, 0);
    chk("tumble_stop_en", motor_en, 0);
    step();

    // Stall with vibration on the fatal tick
    sens_mode = 1;
    vib_mode = 2;
    target_speed = 11'd1000;
    drum_motor = 1'b1;
    peak = 0; n = 0;
    while (!stall_fault && n < 500) begin
      step(); n++;
      if (int'(speed_cmd) > peak) peak = int'(speed_cmd);
    end
    chk("stall_fault", stall_fault, 1);
    chk("stall_no_imb", imbalance_fault, 0);
    chk("stall_peak", peak, 650);
    chk("stall_speed", speed_cmd, 0);
    chk("stall_en", motor_en, 0);
    drum_motor = 1'b0;
    clear_fault = 1'b1;
    step();
    chk("stall_cleared", stall_fault, 0);
    clear_fault = 1'b0;
    sens_mode = 0;
    vib_mode = 0;
    step();

    // Target clamp to 1400
    target_speed = 11'd2047;
    drum_motor = 1'b1;
    n = 0;
    while (!at_speed && n < 400) begin step(); n++; end
    chk("clamp_speed", speed_cmd, 1400);
    drum_motor = 1'b0;
    n = 0;
    while (speed_cmd != 11'd0 && n < 400) begin step(); n++; end
    step(); step();

    // Asynchronous reset mid-ramp at 700
    drum_motor = 1'b1;
    n = 0;
    while (speed_cmd != 11'd700 && n < 400) begin step(); n++; end
    chk("pre_reset_speed", speed_cmd, 700);
    reset = 1'b0;
    #1;
    chk("async_rst_speed", speed_cmd, 0);
    chk("async_rst_en", motor_en, 0);
    chk("async_rst_pwm", motor_pwm, 0);
    chk("async_rst_at_speed", at_speed, 0);
    drum_motor = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_speed", speed_cmd, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
